// File: rtl/store_buffer_if.sv
// store_buffer_pkg / store_buffer_if
//   Package: the data_mem store-kind encoding shared by the pipeline, the
//   store buffer and data_mem.
//   Interface: groups the pipeline-side store/load signals and the data_mem
//   side signals of the store buffer.
//     master : pipeline / driver side (drives st_*, drain_en, ld_*)
//     slave  : store_buffer side (drives st_ready, ld_hazard, mem_*, count, empty)
package store_buffer_pkg;
    typedef enum logic [1:0] {
        NO_STORE = 2'd0,
        SB       = 2'd1,
        SW       = 2'd2,
        SD       = 2'd3
    } mem_store_type_t;
endpackage

interface store_buffer_if #(
    parameter int PTR_BITS = 2
);
    logic                              st_valid;
    store_buffer_pkg::mem_store_type_t st_type;
    logic [63:0]                       st_addr;
    logic [63:0]                       st_data;
    logic                              st_ready;
    logic                              drain_en;
    logic                              ld_valid;
    logic [63:0]                       ld_addr;
    logic                              ld_hazard;
    logic [63:0]                       mem_addr;
    logic [63:0]                       mem_data;
    store_buffer_pkg::mem_store_type_t mem_store_type;
    logic [PTR_BITS:0]                 count;
    logic                              empty;

    modport master (
        output st_valid, st_type, st_addr, st_data, drain_en, ld_valid, ld_addr,
        input  st_ready, ld_hazard, mem_addr, mem_data, mem_store_type, count, empty
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, drain_en, ld_valid, ld_addr,
        output st_ready, ld_hazard, mem_addr, mem_data, mem_store_type, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer
//   In-order store queue between the MEM stage and data_mem. Holds up to DEPTH
//   stores, presents the oldest one to data_mem and retires it when drain_en
//   allows. Flags loads whose doubleword overlaps any queued store.
// Ports
//   clk    : clock, state updates on posedge
//   reset  : synchronous, active-low
//   sb     : store_buffer_if.slave (store enqueue, load hazard, data_mem side,
//            occupancy)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            reset,
    store_buffer_if.slave  sb
);

    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS:0]   cnt;

    mem_store_type_t ent_type [DEPTH];
    logic [63:0]     ent_addr [DEPTH];
    logic [63:0]     ent_data [DEPTH];

    logic                is_empty;
    logic                is_full;
    logic                drain_fire;
    logic                st_ready_int;
    logic                enq_fire;
    logic                hit;
    logic [PTR_BITS-1:0] offs;

    assign is_empty     = (cnt == '0);
    assign is_full      = (cnt == (PTR_BITS+1)'(DEPTH));
    // Gating with reset keeps every handshake output quiet while in reset.
    assign drain_fire   = reset & ~is_empty & sb.drain_en;
    // A full queue can still accept when the head leaves in the same cycle.
    assign st_ready_int = reset & (~is_full | drain_fire);
    assign enq_fire     = sb.st_valid & (sb.st_type != NO_STORE) & st_ready_int;

    assign sb.st_ready      = st_ready_int;
    assign sb.count         = cnt;
    assign sb.empty         = is_empty;
    assign sb.mem_addr      = (reset & ~is_empty) ? ent_addr[rd_ptr] : '0;
    assign sb.mem_data      = (reset & ~is_empty) ? ent_data[rd_ptr] : '0;
    // data_mem only sees a real store type in the cycle the head is retired.
    assign sb.mem_store_type = drain_fire ? ent_type[rd_ptr] : NO_STORE;

    // An entry is live when its distance from the head is below count.
    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_BITS'(i) - rd_ptr;
            if (({1'b0, offs} < cnt) && (ent_addr[i][63:3] == sb.ld_addr[63:3]))
                hit = 1'b1;
        end
    end

    assign sb.ld_hazard = reset & sb.ld_valid & hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire)
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (drain_fire)
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({enq_fire, drain_fire})
                2'b10:   cnt <= cnt + (PTR_BITS+1)'(1);
                2'b01:   cnt <= cnt - (PTR_BITS+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload needs no reset; liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ent_type[wr_ptr] <= sb.st_type;
            ent_addr[wr_ptr] <= sb.st_addr;
            ent_data[wr_ptr] <= sb.st_data;
        end
    end

endmodule
